// File: rtl/tick_gen_multi_if.sv
// Control and status bundle for the multi-channel timebase generator.
// The controller (master) drives clr/en/div_ld/div_i; the generator (slave) returns tick/sq/busy.
interface tick_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    logic                    clr;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       div_ld;
    logic [NUM_CH*CNT_W-1:0] div_i;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       sq_o;
    logic [NUM_CH-1:0]       busy_o;

    modport master (
        output clr, en, div_ld, div_i,
        input  tick_o, sq_o, busy_o
    );

    modport slave (
        input  clr, en, div_ld, div_i,
        output tick_o, sq_o, busy_o
    );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable timebase: per-channel exact-period tick strobes and
// 50%-duty square waves, each with its own shadowed divisor, enable and load strobe.
module tick_gen_multi #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DIV_RST = 50_000_000
) (
    input logic            clk,
    input logic            rst,
    tick_gen_multi_if.slave bus
);
    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0]  cnt     [NUM_CH];
    logic [CNT_W-1:0]  div_act [NUM_CH];
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] sq_r;
    logic [NUM_CH-1:0] busy_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k]     <= '0;
                div_act[k] <= DIV_RST_V;
            end
            tick_r <= '0;
            sq_r   <= '0;
            busy_r <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                busy_r[k] <= bus.en[k] && (div_act[k] != '0);

                // clr wins over load for the counters, but a simultaneous load still lands.
                if (bus.clr) begin
                    cnt[k]    <= '0;
                    tick_r[k] <= 1'b0;
                    sq_r[k]   <= 1'b0;
                    if (bus.div_ld[k]) begin
                        div_act[k] <= bus.div_i[k*CNT_W +: CNT_W];
                    end
                end else if (bus.div_ld[k]) begin
                    div_act[k] <= bus.div_i[k*CNT_W +: CNT_W];
                    cnt[k]     <= '0;
                    tick_r[k]  <= 1'b0;
                end else if (bus.en[k] && (div_act[k] != '0)) begin
                    // Terminal count at D-1 gives an exact D-cycle period; D=1 ticks every cycle.
                    if (cnt[k] == div_act[k] - ONE) begin
                        cnt[k]    <= '0;
                        tick_r[k] <= 1'b1;
                        sq_r[k]   <= ~sq_r[k];
                    end else begin
                        cnt[k]    <= cnt[k] + ONE;
                        tick_r[k] <= 1'b0;
                    end
                end else begin
                    tick_r[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.tick_o = tick_r;
    assign bus.sq_o   = sq_r;
    assign bus.busy_o = busy_r;
endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: a per-cycle reference model (enabled-cycle counting with
// modulo arithmetic, tick parity for the square wave) plus directed literal checks.
module tb_tick_gen_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DIVR   = 10;

    logic clk;
    logic rst;

    tick_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    tick_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(DIVR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n_en: enabled cycles since the last restart; a tick falls on every multiple of D.
    // n_tick: ticks since the last clear; the square wave is its parity.
    longint unsigned   n_en   [NUM_CH];
    int unsigned       n_tick [NUM_CH];
    logic [CNT_W-1:0]  m_div  [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_busy;

    function automatic logic [NUM_CH-1:0] m_sq();
        logic [NUM_CH-1:0] s;
        for (int k = 0; k < NUM_CH; k++) s[k] = n_tick[k][0];
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            n_en[k]   = 0;
            n_tick[k] = 0;
            m_div[k]  = CNT_W'(DIVR);
        end
        m_tick = '0;
        m_busy = '0;
    endtask

    task automatic model_step();
        logic [CNT_W-1:0] new_div;
        for (int k = 0; k < NUM_CH; k++) begin
            new_div   = bus.div_i[k*CNT_W +: CNT_W];
            m_busy[k] = bus.en[k] && (m_div[k] != 0);
            if (bus.clr) begin
                n_en[k]   = 0;
                n_tick[k] = 0;
                m_tick[k] = 1'b0;
                if (bus.div_ld[k]) m_div[k] = new_div;
            end else if (bus.div_ld[k]) begin
                m_div[k]  = new_div;
                n_en[k]   = 0;
                m_tick[k] = 1'b0;
            end else if (bus.en[k] && m_div[k] != 0) begin
                n_en[k]++;
                m_tick[k] = ((n_en[k] % longint'(m_div[k])) == 0);
                if (m_tick[k]) n_tick[k]++;
            end else begin
                m_tick[k] = 1'b0;
            end
        end
    endtask

    // Single compare process: advance the model on each edge, compare 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
            #1;
            if (checking) begin
                check("cyc_tick", 32'(bus.tick_o), 32'(m_tick));
                check("cyc_sq",   32'(bus.sq_o),   32'(m_sq()));
                check("cyc_busy", 32'(bus.busy_o), 32'(m_busy));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_div(input int k, input logic [CNT_W-1:0] v);
        bus.div_i[k*CNT_W +: CNT_W] = v;
    endtask

    task automatic load(input logic [NUM_CH-1:0] mask);
        @(negedge clk);
        bus.div_ld = mask;
        @(negedge clk);
        bus.div_ld = '0;
    endtask

    // Samples n cycles; first is the 1-based sample index of the first tick, 0 if none.
    task automatic count_ticks(input int ch, input int n, output int ticks, output int first);
        ticks = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.tick_o[ch]) begin
                ticks++;
                if (first == 0) first = i;
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    int t;
    int f;
    int firsts [NUM_CH];

    initial begin
        rst        = 1'b1;
        bus.clr    = 1'b0;
        bus.en     = '0;
        bus.div_ld = '0;
        bus.div_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_tick", 32'(bus.tick_o), 32'd0);
        check("rst_sq",   32'(bus.sq_o),   32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst      = 1'b0;
        checking = 1'b1;

        // ch0 divisor 5: tick every 5 cycles, sq toggles per tick
        bus.en = 4'b0001;
        set_div(0, 5);
        load(4'b0001);
        count_ticks(0, 5, t, f);
        check("d5_first", 32'(f), 32'd5);
        check("d5_sq1", 32'(bus.sq_o[0]), 32'd1);
        count_ticks(0, 15, t, f);
        check("d5_count", 32'(t), 32'd3);
        check("d5_sq0", 32'(bus.sq_o[0]), 32'd0);

        // ch1 divisor 1 ticks every cycle; ch2 divisor 0 is stopped
        set_div(1, 1);
        set_div(2, 0);
        bus.en = 4'b0111;
        load(4'b0110);
        count_ticks(1, 8, t, f);
        check("d1_count", 32'(t), 32'd8);
        check("d1_first", 32'(f), 32'd1);
        count_ticks(2, 8, t, f);
        check("d0_count", 32'(t), 32'd0);
        check("d0_busy", 32'(bus.busy_o[2]), 32'd0);
        check("d1_busy", 32'(bus.busy_o[1]), 32'd1);

        // ch0 divisor 8: disable with count at 4, hold 10 cycles, resume from the held count
        bus.en = 4'b0001;
        set_div(0, 8);
        load(4'b0001);
        count_ticks(0, 4, t, f);
        check("en_pre", 32'(t), 32'd0);
        bus.en = 4'b0000;
        count_ticks(0, 10, t, f);
        check("en_off", 32'(t), 32'd0);
        bus.en = 4'b0001;
        count_ticks(0, 6, t, f);
        check("en_resume_first", 32'(f), 32'd4);
        check("en_resume_count", 32'(t), 32'd1);

        // div_i changes are shadowed until div_ld
        set_div(0, 6);
        load(4'b0001);
        count_ticks(0, 12, t, f);
        check("d6_count", 32'(t), 32'd2);
        check("d6_first", 32'(f), 32'd6);
        set_div(0, 3);
        count_ticks(0, 12, t, f);
        check("shadow_count", 32'(t), 32'd2);
        check("shadow_first", 32'(f), 32'd6);
        load(4'b0001);
        count_ticks(0, 9, t, f);
        check("d3_count", 32'(t), 32'd3);
        check("d3_first", 32'(f), 32'd3);

        // clr together with div_ld mid-count
        bus.en = 4'b1111;
        count_ticks(0, 2, t, f);
        set_div(0, 4);
        bus.clr    = 1'b1;
        bus.div_ld = 4'b0001;
        @(negedge clk);
        bus.clr    = 1'b0;
        bus.div_ld = '0;
        check("clr_sq",   32'(bus.sq_o),   32'd0);
        check("clr_tick", 32'(bus.tick_o), 32'd0);
        count_ticks(0, 8, t, f);
        check("clr_d4_count", 32'(t), 32'd2);
        check("clr_d4_first", 32'(f), 32'd4);

        // asynchronous reset between edges, then every channel runs at the reset divisor
        count_ticks(0, 3, t, f);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_tick", 32'(bus.tick_o), 32'd0);
        check("arst_sq",   32'(bus.sq_o),   32'd0);
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        bus.en = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        bus.en = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) firsts[k] = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++)
                if (bus.tick_o[k] && firsts[k] == 0) firsts[k] = i;
        end
        for (int k = 0; k < NUM_CH; k++) check($sformatf("divrst_first_ch%0d", k), 32'(firsts[k]), 32'd10);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
